// File: rtl/peripheral_bus_hub_pkg.sv
// peripheral_bus_hub_pkg: shared FSM/source encodings and the address window compare used by the bus hub
package peripheral_bus_hub_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} pbh_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_INTA, SRC_DMA, SRC_SLOT} pbh_src_t;
  function automatic logic pbh_window_hit(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] mask);
    return ((addr ^ base) & mask) == '0;
  endfunction
endpackage

// File: rtl/peripheral_bus_hub_if.sv
// peripheral_bus_hub_if: CPU/DMA side strobes, slave read-back lines and hub outputs; master = bus owner, slave = hub
interface peripheral_bus_hub_if #(
  parameter int N_SLOTS = 8,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 8
) ();
  logic [ADDR_W-1:0]         address;
  logic                      io_read_n;
  logic                      io_write_n;
  logic                      memory_read_n;
  logic                      memory_write_n;
  logic                      address_enable_n;
  logic                      interrupt_acknowledge_n;
  logic                      dma_ack;
  logic [DATA_W-1:0]         inta_data_in;
  logic [DATA_W-1:0]         dma_data_in;
  logic [N_SLOTS*DATA_W-1:0] slot_data_in;
  logic [N_SLOTS-1:0]        slot_ready;
  logic [N_SLOTS-1:0]        slot_chip_select_n;
  logic [DATA_W-1:0]         data_bus_out;
  logic                      data_bus_out_from_chipset;
  logic                      io_channel_ready;
  logic                      bus_error;
  modport master (
    output address, io_read_n, io_write_n, memory_read_n, memory_write_n, address_enable_n,
           interrupt_acknowledge_n, dma_ack, inta_data_in, dma_data_in, slot_data_in, slot_ready,
    input  slot_chip_select_n, data_bus_out, data_bus_out_from_chipset, io_channel_ready, bus_error
  );
  modport slave (
    input  address, io_read_n, io_write_n, memory_read_n, memory_write_n, address_enable_n,
           interrupt_acknowledge_n, dma_ack, inta_data_in, dma_data_in, slot_data_in, slot_ready,
    output slot_chip_select_n, data_bus_out, data_bus_out_from_chipset, io_channel_ready, bus_error
  );
endinterface

// File: rtl/peripheral_bus_hub_slot_decoder.sv
// pbh_slot_decoder: combinational window match over all slots, lowest matching index wins
module pbh_slot_decoder
  import peripheral_bus_hub_pkg::*;
#(
  parameter int                       N_SLOTS     = 8,
  parameter int                       ADDR_W      = 20,
  parameter int                       IDX_W       = 3,
  parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_BASE  = '0,
  parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_MASK  = '0,
  parameter logic [N_SLOTS-1:0]        SLOT_IS_MEM = '0
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              io_en,
  input  logic              mem_en,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);
  // scan from the top so the lowest matching slot is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if ((SLOT_IS_MEM[i] ? mem_en : io_en) &&
          pbh_window_hit(32'(address), 32'(SLOT_BASE[i*ADDR_W +: ADDR_W]), 32'(SLOT_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
  end
endmodule

// File: rtl/peripheral_bus_hub.sv
// peripheral_bus_hub: chip-select decode, wait-state insertion and registered read-back; PBH_TIMEOUT_EN adds a ready timeout with bus_error
module peripheral_bus_hub
  import peripheral_bus_hub_pkg::*;
#(
  parameter int                        N_SLOTS     = 8,
  parameter int                        ADDR_W      = 20,
  parameter int                        DATA_W      = 8,
  parameter int                        WAIT_W      = 3,
  parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_BASE   = '0,
  parameter logic [N_SLOTS*ADDR_W-1:0] SLOT_MASK   = '0,
  parameter logic [N_SLOTS-1:0]        SLOT_IS_MEM = '0,
  parameter logic [N_SLOTS*WAIT_W-1:0] SLOT_WAIT   = '0,
  parameter int                        TIMEOUT_CYC = 255
) (
  input logic                 clock,
  input logic                 reset,
  peripheral_bus_hub_if.slave bus
);
  localparam int IDX_W = N_SLOTS > 1 ? $clog2(N_SLOTS) : 1;
  logic io_strb, mem_strb, strb, rd, hit, cur_rdy;
  logic [IDX_W-1:0] hit_idx, idx_q, cur_idx;
  logic [WAIT_W-1:0] wcnt, nwcnt, load_w;
  logic [DATA_W-1:0] sel_data, dout;
  logic [N_SLOTS-1:0] cs_n;
  logic from_cs, rdy, berr;
  pbh_src_t nsrc, src_q, cur_src;
  pbh_state_t state;
`ifdef PBH_TIMEOUT_EN
  localparam int TC_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  logic [TC_W-1:0] tcnt;
`endif

  assign io_strb  = ~bus.io_read_n | ~bus.io_write_n;
  assign mem_strb = ~bus.memory_read_n | ~bus.memory_write_n;
  assign strb     = io_strb | mem_strb | ~bus.interrupt_acknowledge_n;
  assign rd       = ~bus.io_read_n | ~bus.memory_read_n | ~bus.interrupt_acknowledge_n;

  pbh_slot_decoder #(
    .N_SLOTS(N_SLOTS), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
    .SLOT_BASE(SLOT_BASE), .SLOT_MASK(SLOT_MASK), .SLOT_IS_MEM(SLOT_IS_MEM)
  ) u_dec (
    .address(bus.address),
    .io_en(io_strb & ~bus.address_enable_n),
    .mem_en(mem_strb),
    .hit(hit),
    .idx(hit_idx)
  );

  // in IDLE the live decode is used, afterwards the source latched at cycle start
  always_comb begin
    nsrc     = ~bus.interrupt_acknowledge_n ? SRC_INTA :
               (bus.dma_ack & ~bus.io_read_n) ? SRC_DMA : hit ? SRC_SLOT : SRC_NONE;
    cur_src  = state == IDLE ? nsrc : src_q;
    cur_idx  = state == IDLE ? hit_idx : idx_q;
    load_w   = nsrc == SRC_SLOT ? SLOT_WAIT[hit_idx*WAIT_W +: WAIT_W] : '0;
    nwcnt    = wcnt == '0 ? '0 : wcnt - WAIT_W'(1);
    cur_rdy  = cur_src != SRC_SLOT || bus.slot_ready[cur_idx];
    sel_data = cur_src == SRC_INTA ? bus.inta_data_in :
               cur_src == SRC_DMA  ? bus.dma_data_in  :
               cur_src == SRC_SLOT ? bus.slot_data_in[cur_idx*DATA_W +: DATA_W] : '0;
  end

  // bus cycle FSM with registered chip selects, ready and read-back data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      src_q   <= SRC_NONE;
      idx_q   <= '0;
      wcnt    <= '0;
      cs_n    <= '1;
      dout    <= '0;
      from_cs <= 1'b0;
      rdy     <= 1'b1;
      berr    <= 1'b0;
`ifdef PBH_TIMEOUT_EN
      tcnt    <= '0;
`endif
    end else begin
      berr <= 1'b0;
      case (state)
        IDLE: if (strb) begin
          src_q <= nsrc;
          idx_q <= hit_idx;
          wcnt  <= load_w;
          cs_n  <= nsrc == SRC_SLOT ? ~(N_SLOTS'(1) << hit_idx) : '1;
`ifdef PBH_TIMEOUT_EN
          tcnt  <= '0;
`endif
          if (load_w == '0 && cur_rdy) begin
            state   <= DONE;
            from_cs <= rd && nsrc != SRC_NONE;
            if (rd && nsrc != SRC_NONE) dout <= sel_data;
          end else begin
            state <= WAIT;
            rdy   <= 1'b0;
          end
        end
        WAIT: if (!strb) begin
          state <= IDLE;
          cs_n  <= '1;
          rdy   <= 1'b1;
        end else begin
          wcnt <= nwcnt;
          if (nwcnt == '0 && cur_rdy) begin
            state   <= DONE;
            rdy     <= 1'b1;
            from_cs <= rd;
            if (rd) dout <= sel_data;
          end
`ifdef PBH_TIMEOUT_EN
          else if (nwcnt == '0) begin
            tcnt <= tcnt + TC_W'(1);
            if (tcnt == TC_W'(TIMEOUT_CYC - 1)) begin
              state   <= DONE;
              rdy     <= 1'b1;
              from_cs <= rd;
              dout    <= '1;
              berr    <= 1'b1;
            end
          end
`endif
        end
        DONE: if (!strb) begin
          state   <= IDLE;
          cs_n    <= '1;
          from_cs <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.slot_chip_select_n        = cs_n;
  assign bus.data_bus_out              = dout;
  assign bus.data_bus_out_from_chipset = from_cs;
  assign bus.io_channel_ready          = rdy;
  assign bus.bus_error                 = berr;
endmodule

// File: tb/tb_peripheral_bus_hub.sv
// tb_peripheral_bus_hub: directed and randomized bus cycles checked against a window/priority reference model
module tb_peripheral_bus_hub;
  localparam int N = 8, AW = 20, DW = 8, WW = 3;
`ifdef PBH_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  localparam logic [N*AW-1:0] BASE = {20'hF0000, 20'hB0000, 20'hB8000, 20'h003F0,
                                      20'h00060, 20'h00040, 20'h00020, 20'h00000};
  localparam logic [N*AW-1:0] MASK = {20'hF0000, 20'hF0000, 20'hF8000, 20'h003F8,
                                      20'h003E0, 20'h003E0, 20'h003E0, 20'h003E0};
  localparam logic [N-1:0]    IS_MEM = 8'b1110_0000;
  localparam logic [N*WW-1:0] WAITS = {3'd2, 3'd0, 3'd1, 3'd3, 3'd0, 3'd2, 3'd0, 3'd1};

  logic clock = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_dout;
  logic [AW-1:0] addr_pool [10] = '{20'h00021, 20'h00005, 20'h00041, 20'h00063, 20'h003F5,
                                    20'h00100, 20'hB8123, 20'hB1234, 20'hF0ABC, 20'h40000};

  peripheral_bus_hub_if #(.N_SLOTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  peripheral_bus_hub #(
    .N_SLOTS(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_W(WW),
    .SLOT_BASE(BASE), .SLOT_MASK(MASK), .SLOT_IS_MEM(IS_MEM), .SLOT_WAIT(WAITS),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference decode: first slot whose strobe type and masked address agree, -1 when none
  function automatic int exp_slot(input logic [AW-1:0] a, input bit io, input bit mem, input bit aen_n);
    for (int i = 0; i < N; i++) begin
      logic [AW-1:0] b, m;
      b = BASE[i*AW +: AW];
      m = MASK[i*AW +: AW];
      if ((IS_MEM[i] ? mem : (io && !aen_n)) && ((a & m) == (b & m))) return i;
    end
    return -1;
  endfunction

  task automatic idle_bus();
    bus.io_read_n = 1'b1;
    bus.io_write_n = 1'b1;
    bus.memory_read_n = 1'b1;
    bus.memory_write_n = 1'b1;
    bus.interrupt_acknowledge_n = 1'b1;
    bus.dma_ack = 1'b0;
    bus.address_enable_n = 1'b0;
    bus.slot_ready = '1;
  endtask

  task automatic rand_data();
    bus.slot_data_in = {$urandom, $urandom};
    bus.inta_data_in = DW'($urandom);
    bus.dma_data_in = DW'($urandom);
  endtask

  task automatic drive(input int op, input logic [AW-1:0] a, input bit aen_n, input bit dma);
    bus.address = a;
    bus.address_enable_n = aen_n;
    bus.dma_ack = dma;
    bus.io_read_n = !(op == 0);
    bus.io_write_n = !(op == 1);
    bus.memory_read_n = !(op == 2);
    bus.memory_write_n = !(op == 3);
    bus.interrupt_acknowledge_n = !(op == 4);
  endtask

  // op: 0 io read, 1 io write, 2 mem read, 3 mem write, 4 INTA; rdy_lo: clocks slot_ready is held low
  task automatic txn(input string tag, input int op, input logic [AW-1:0] a, input bit aen_n,
                     input bit dma, input int rdy_lo);
    int s, k, lows;
    bit rdv, has;
    logic [DW-1:0] d, ecs;
    @(negedge clock);
    drive(op, a, aen_n, dma);
    bus.slot_ready = rdy_lo > 0 ? '0 : '1;
    s = exp_slot(a, op < 2, op == 2 || op == 3, aen_n);
    rdv = op == 0 || op == 2 || op == 4;
    has = 1'b1;
    k = 0;
    ecs = 8'hFF;
    d = '0;
    if (op == 4) d = bus.inta_data_in;
    else if (dma && op == 0) d = bus.dma_data_in;
    else if (s >= 0) begin
      d = bus.slot_data_in[s*DW +: DW];
      k = int'(WAITS[s*WW +: WW]);
      if (rdy_lo > k) k = rdy_lo;
      ecs = ~(8'd1 << s);
    end else has = 1'b0;
    if (rdv && has) exp_dout = d;
    @(negedge clock);
    check({tag, "_cs_start"}, bus.slot_chip_select_n, ecs);
    lows = 0;
    while (!bus.io_channel_ready && lows < 64) begin
      lows++;
      if (lows == rdy_lo) bus.slot_ready = '1;
      @(negedge clock);
    end
    bus.slot_ready = '1;
    check({tag, "_wait_clocks"}, lows, k);
    check({tag, "_cs_done"}, bus.slot_chip_select_n, ecs);
    check({tag, "_data"}, bus.data_bus_out, exp_dout);
    check({tag, "_from_chipset"}, bus.data_bus_out_from_chipset, rdv && has);
    check({tag, "_bus_error"}, bus.bus_error, 1'b0);
    idle_bus();
    @(negedge clock);
    check({tag, "_cs_release"}, bus.slot_chip_select_n, 8'hFF);
    check({tag, "_from_clear"}, bus.data_bus_out_from_chipset, 1'b0);
    check({tag, "_ready_idle"}, bus.io_channel_ready, 1'b1);
  endtask

  initial begin
    int lows;
    bit seen_err;
    idle_bus();
    rand_data();
    bus.address = 20'h00021;
    bus.io_read_n = 1'b0;
    reset = 1'b1;
    exp_dout = '0;
    repeat (3) @(negedge clock);
    check("rst_cs", bus.slot_chip_select_n, 8'hFF);
    check("rst_ready", bus.io_channel_ready, 1'b1);
    check("rst_from", bus.data_bus_out_from_chipset, 1'b0);
    check("rst_data", bus.data_bus_out, 8'h00);
    check("rst_berr", bus.bus_error, 1'b0);
    idle_bus();
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_cs", bus.slot_chip_select_n, 8'hFF);
    check("rst_release_ready", bus.io_channel_ready, 1'b1);

    rand_data();
    bus.slot_data_in[1*DW +: DW] = 8'h5A;
    txn("io_rd_slot1", 0, 20'h00021, 1'b0, 1'b0, 0);
    check("io_rd_slot1_value", bus.data_bus_out, 8'h5A);

    rand_data();
    txn("wait_slot4", 0, 20'h003F2, 1'b0, 1'b0, 5);

    rand_data();
    bus.inta_data_in = 8'h08;
    txn("inta_prio", 4, 20'h00005, 1'b0, 1'b0, 0);
    check("inta_prio_value", bus.data_bus_out, 8'h08);

    rand_data();
    txn("dma_prio", 0, 20'h00021, 1'b1, 1'b1, 0);
    rand_data();
    txn("aen_block", 0, 20'h00060, 1'b1, 1'b0, 0);
    rand_data();
    txn("io_write", 1, 20'h00041, 1'b0, 1'b0, 0);
    rand_data();
    txn("mem_overlap", 2, 20'hB8010, 1'b0, 1'b0, 0);
    rand_data();
    txn("mem_nomatch", 2, 20'h40000, 1'b0, 1'b0, 0);

    rand_data();
    @(negedge clock);
    drive(0, 20'h003F2, 1'b0, 1'b0);
    @(negedge clock);
    check("abort_cs", bus.slot_chip_select_n, 8'hEF);
    check("abort_wait", bus.io_channel_ready, 1'b0);
    idle_bus();
    @(negedge clock);
    check("abort_cs_release", bus.slot_chip_select_n, 8'hFF);
    check("abort_ready", bus.io_channel_ready, 1'b1);
    check("abort_from", bus.data_bus_out_from_chipset, 1'b0);
    check("abort_data", bus.data_bus_out, exp_dout);

    rand_data();
    @(negedge clock);
    drive(0, 20'h00021, 1'b0, 1'b0);
    bus.slot_ready = '0;
    lows = 0;
    seen_err = 1'b0;
    @(negedge clock);
    while (!bus.io_channel_ready && lows < 40) begin
      lows++;
      seen_err |= bus.bus_error;
      @(negedge clock);
    end
`ifdef PBH_TIMEOUT_EN
    check("timeout_clocks", lows, TO);
    check("timeout_data", bus.data_bus_out, 8'hFF);
    check("timeout_berr", bus.bus_error, 1'b1);
    check("timeout_from", bus.data_bus_out_from_chipset, 1'b1);
    check("timeout_berr_early", seen_err, 1'b0);
    exp_dout = 8'hFF;
    @(negedge clock);
    check("timeout_berr_pulse", bus.bus_error, 1'b0);
`else
    check("stuck_wait_persists", bus.io_channel_ready, 1'b0);
    check("stuck_no_berr", seen_err | bus.bus_error, 1'b0);
`endif
    idle_bus();
    @(negedge clock);
    check("stuck_cs_release", bus.slot_chip_select_n, 8'hFF);
    check("stuck_ready", bus.io_channel_ready, 1'b1);

    for (int t = 0; t < 60; t++) begin
      int op;
      logic [AW-1:0] a;
      rand_data();
      op = $urandom_range(0, 9) == 0 ? 4 : int'($urandom_range(0, 3));
      a = $urandom_range(0, 4) == 0 ? AW'($urandom) : addr_pool[$urandom_range(0, 9)];
      txn("rand", op, a, $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)));
    end

    rand_data();
    @(negedge clock);
    drive(0, 20'h003F2, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_cs", bus.slot_chip_select_n, 8'hFF);
    check("async_rst_ready", bus.io_channel_ready, 1'b1);
    check("async_rst_data", bus.data_bus_out, 8'h00);
    idle_bus();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("async_rst_idle", bus.slot_chip_select_n, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
